data_mem_access_unit: RTL and testbench

//  Initiator side of the ram256x8 data-memory interface (Enable/ReadWrite/Address/DataIn/Size/SE -> DataOut).

---
 rtl/data_mem_access_unit.sv | 182 ++++++++++++++++++
 tb/tb_data_mem_access_unit.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_access_unit.sv
// ============================================================================
// data_mem_access_unit
// ----------------------------------------------------------------------------
// Purpose:
//   This is the initiator side of the ram256x8 data-memory interface. It takes
//   one load/store request at a time from the MEM stage over a valid/ready
//   handshake and checks its alignment. It then drives the RAM for MEM_LATENCY
//   cycles, captures the read data and returns one response over a
//   valid/ready handshake.
//
// Configuration macro:
//   DMAU_ALIGN_CHECK_EN
//     defined   : Size 11, an odd halfword address and a word address that is
//                 not 4-aligned are rejected with RspErr=1. The RAM is not
//                 accessed for a rejected request.
//     undefined : no request is rejected and RspErr stays 0. Size 11 is
//                 treated as a word. The address is aligned down to the
//                 access size.
//
// Parameters:
//   ADDR_W       byte-address width (8 -> 256-byte RAM)
//   MEM_LATENCY  cycles the RAM is enabled before DataOut is sampled (1..15)
//
// Ports:
//   clk, rst_n                clock (rising edge), async active-low reset
//   ReqValid/ReqReady         request handshake
//   ReqWrite/ReqAddr/ReqSize  request kind, byte address, size (00 b,01 h,10 w)
//   ReqSE/ReqData             load sign-extend select, right-justified store data
//   RspValid/RspReady         response handshake
//   RspData/RspErr            load data (0 for stores/errors), reject flag
//   Mem*                      RAM control/address/data/size/SE outputs
//   MemDataOut                combinational read data from RAM
// ============================================================================
module data_mem_access_unit #(
    parameter int ADDR_W      = 8,
    parameter int MEM_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ReqValid,
    output logic              ReqReady,
    input  logic              ReqWrite,
    input  logic [ADDR_W-1:0] ReqAddr,
    input  logic [1:0]        ReqSize,
    input  logic              ReqSE,
    input  logic [31:0]       ReqData,
    output logic              RspValid,
    input  logic              RspReady,
    output logic [31:0]       RspData,
    output logic              RspErr,
    output logic              MemEnable,
    output logic              MemReadWrite,
    output logic [ADDR_W-1:0] MemAddress,
    output logic [31:0]       MemDataIn,
    output logic [1:0]        MemSize,
    output logic              MemSE,
    input  logic [31:0]       MemDataOut
);

    localparam logic [3:0] LAT = 4'(MEM_LATENCY);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [3:0]          r_cnt;
    logic                r_write;
    logic [ADDR_W-1:0]   r_addr;
    logic [1:0]          r_size;
    logic                r_se;
    logic [31:0]         r_data;
    logic [31:0]         r_rsp_data;
    logic                r_rsp_err;

    logic                w_accept;
    logic                w_illegal;
    logic [ADDR_W-1:0]   w_addr;
    logic [1:0]          w_size;

    // Classify the incoming request. It is either rejected here, or its
    // address and size are rewritten to form an aligned-down access.
`ifdef DMAU_ALIGN_CHECK_EN
    always_comb begin
        w_size    = ReqSize;
        w_addr    = ReqAddr;
        w_illegal = (ReqSize == 2'b11) ||
                    (ReqSize == 2'b01 && ReqAddr[0]) ||
                    (ReqSize == 2'b10 && ReqAddr[1:0] != 2'b00);
    end
`else
    always_comb begin
        w_illegal = 1'b0;
        w_size    = (ReqSize == 2'b11) ? 2'b10 : ReqSize;
        w_addr    = ReqAddr;
        if (w_size == 2'b01)
            w_addr[0] = 1'b0;
        else if (w_size == 2'b10)
            w_addr[1:0] = 2'b00;
    end
`endif

    assign w_accept = ReqValid && (r_state == S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // Handshake and RAM strobes decode from the state register alone. An
    // async reset of the state therefore drops them immediately.
    always_comb begin
        w_next       = r_state;
        ReqReady     = 1'b0;
        RspValid     = 1'b0;
        MemEnable    = 1'b0;
        MemReadWrite = 1'b0;
        case (r_state)
            S_IDLE: begin
                ReqReady = 1'b1;
                if (ReqValid)
                    w_next = w_illegal ? S_RESP : S_ACCESS;
            end
            S_ACCESS: begin
                MemEnable    = 1'b1;
                MemReadWrite = r_write;
                if (r_cnt <= 4'd1)
                    w_next = S_RESP;
            end
            S_RESP: begin
                RspValid = 1'b1;
                if (RspReady)
                    w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= 4'd0;
            r_write    <= 1'b0;
            r_addr     <= '0;
            r_size     <= 2'b00;
            r_se       <= 1'b0;
            r_data     <= 32'd0;
            r_rsp_data <= 32'd0;
            r_rsp_err  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_write    <= ReqWrite;
                r_addr     <= w_addr;
                r_size     <= w_size;
                r_se       <= ReqSE;
                r_data     <= ReqData;
                r_rsp_data <= 32'd0;
                r_rsp_err  <= w_illegal;
                r_cnt      <= w_illegal ? 4'd0 : LAT;
            end
            if (r_state == S_ACCESS) begin
                r_cnt <= r_cnt - 4'd1;
                // Last enabled cycle: the RAM output is valid now.
                if (r_cnt <= 4'd1)
                    r_rsp_data <= r_write ? 32'd0 : MemDataOut;
            end
        end
    end

    // Address/data lines hold the last latched request; MemEnable qualifies them.
    assign MemAddress = r_addr;
    assign MemDataIn  = r_data;
    assign MemSize    = r_size;
    assign MemSE      = r_se;
    assign RspData    = r_rsp_data;
    assign RspErr     = r_rsp_err;

endmodule

// File: tb/tb_data_mem_access_unit.sv
module tb_data_mem_access_unit;

    logic clk = 1'b0;
    logic rst_n;
    logic mem_clr;

    always #5 clk = ~clk;

    // Index 0: MEM_LATENCY=1, index 1: MEM_LATENCY=3
    logic [1:0]        req_valid, req_write, req_se, rsp_ready;
    logic [1:0][7:0]   req_addr;
    logic [1:0][1:0]   req_size;
    logic [1:0][31:0]  req_data;
    logic [1:0]        req_ready, rsp_valid, rsp_err;
    logic [1:0][31:0]  rsp_data;
    logic [1:0]        mem_en, mem_rw, mem_se;
    logic [1:0][7:0]   mem_addr;
    logic [1:0][31:0]  mem_din;
    logic [1:0][1:0]   mem_size;
    logic [1:0][31:0]  mem_dout;

    logic [7:0] mem [2][256];

    int n_total = 0;
    int n_bad   = 0;

    data_mem_access_unit #(.ADDR_W(8), .MEM_LATENCY(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .ReqValid(req_valid[0]), .ReqReady(req_ready[0]), .ReqWrite(req_write[0]),
        .ReqAddr(req_addr[0]), .ReqSize(req_size[0]), .ReqSE(req_se[0]),
        .ReqData(req_data[0]), .RspValid(rsp_valid[0]), .RspReady(rsp_ready[0]),
        .RspData(rsp_data[0]), .RspErr(rsp_err[0]), .MemEnable(mem_en[0]),
        .MemReadWrite(mem_rw[0]), .MemAddress(mem_addr[0]), .MemDataIn(mem_din[0]),
        .MemSize(mem_size[0]), .MemSE(mem_se[0]), .MemDataOut(mem_dout[0])
    );

    data_mem_access_unit #(.ADDR_W(8), .MEM_LATENCY(3)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .ReqValid(req_valid[1]), .ReqReady(req_ready[1]), .ReqWrite(req_write[1]),
        .ReqAddr(req_addr[1]), .ReqSize(req_size[1]), .ReqSE(req_se[1]),
        .ReqData(req_data[1]), .RspValid(rsp_valid[1]), .RspReady(rsp_ready[1]),
        .RspData(rsp_data[1]), .RspErr(rsp_err[1]), .MemEnable(mem_en[1]),
        .MemReadWrite(mem_rw[1]), .MemAddress(mem_addr[1]), .MemDataIn(mem_din[1]),
        .MemSize(mem_size[1]), .MemSE(mem_se[1]), .MemDataOut(mem_dout[1])
    );

    // Big-endian ram256x8 model: combinational read, write on clock edge
    function automatic logic [31:0] ram_rd(input int k, input logic [7:0] a,
                                           input logic [1:0] sz, input logic se);
        logic [7:0] b0, b1, b2, b3;
        b0 = mem[k][a];
        b1 = mem[k][a + 8'd1];
        b2 = mem[k][a + 8'd2];
        b3 = mem[k][a + 8'd3];
        case (sz)
            2'b00:   ram_rd = se ? {{24{b0[7]}}, b0} : {24'd0, b0};
            2'b01:   ram_rd = se ? {{16{b0[7]}}, b0, b1} : {16'd0, b0, b1};
            default: ram_rd = {b0, b1, b2, b3};
        endcase
    endfunction

    always_comb begin
        mem_dout = '0;
        for (int k = 0; k < 2; k++)
            mem_dout[k] = ram_rd(k, mem_addr[k], mem_size[k], mem_se[k]);
    end

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (mem_clr) begin
                for (int i = 0; i < 256; i++) mem[k][i] <= 8'h00;
            end else if (mem_en[k] && mem_rw[k]) begin
                case (mem_size[k])
                    2'b00: mem[k][mem_addr[k]] <= mem_din[k][7:0];
                    2'b01: begin
                        mem[k][mem_addr[k]]        <= mem_din[k][15:8];
                        mem[k][mem_addr[k] + 8'd1] <= mem_din[k][7:0];
                    end
                    default: begin
                        mem[k][mem_addr[k]]        <= mem_din[k][31:24];
                        mem[k][mem_addr[k] + 8'd1] <= mem_din[k][23:16];
                        mem[k][mem_addr[k] + 8'd2] <= mem_din[k][15:8];
                        mem[k][mem_addr[k] + 8'd3] <= mem_din[k][7:0];
                    end
                endcase
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One full transaction. lat counts falling edges after the accepting
    // rising edge up to the first one that shows RspValid; en counts those
    // falling edges that show MemEnable.
    task automatic xact(input int k, input logic w, input logic [7:0] a,
                        input logic [1:0] sz, input logic se, input logic [31:0] d,
                        output logic [31:0] rd, output logic er,
                        output int lat, output int en);
        int t;
        @(negedge clk);
        req_valid[k] = 1'b1;
        req_write[k] = w;
        req_addr[k]  = a;
        req_size[k]  = sz;
        req_se[k]    = se;
        req_data[k]  = d;
        t = 0;
        while (!req_ready[k] && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready[k]) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1 req_valid[k] = 1'b0;
        lat = 0;
        en  = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (mem_en[k]) en++;
            if (rsp_valid[k]) break;
        end
        if (!rsp_valid[k]) chk("rsp_timeout", 32'd0, 32'd1);
        rd = rsp_data[k];
        er = rsp_err[k];
        rsp_ready[k] = 1'b1;
        @(posedge clk);
        #1 rsp_ready[k] = 1'b0;
    endtask

    task automatic run(input string tag, input int k, input logic w, input logic [7:0] a,
                       input logic [1:0] sz, input logic se, input logic [31:0] d,
                       input logic [31:0] exp_d, input logic exp_e,
                       input int exp_lat, input int exp_en);
        logic [31:0] rd;
        logic        er;
        int          lat, en;
        xact(k, w, a, sz, se, d, rd, er, lat, en);
        chk({tag, "_data"}, rd, exp_d);
        chk({tag, "_err"}, {31'd0, er}, {31'd0, exp_e});
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_en"}, en, exp_en);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int seen;
        rst_n     = 1'b0;
        mem_clr   = 1'b1;
        req_valid = '0; req_write = '0; req_se = '0; rsp_ready = '0;
        req_addr  = '0; req_size  = '0; req_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {31'd0, req_ready[0]}, 32'd1);
        chk("rst_rspv",  {31'd0, rsp_valid[0]}, 32'd0);
        chk("rst_en",    {30'd0, mem_en}, 32'd0);
        chk("rst_rdata", rsp_data[0], 32'd0);
        chk("rst_addr",  {24'd0, mem_addr[0]}, 32'd0);
        rst_n   = 1'b1;
        mem_clr = 1'b0;

        // MEM_LATENCY=1: stores, then loads of the big-endian layout
        run("st_b0",  0, 1'b1, 8'd0, 2'b00, 1'b0, 32'h0000_00A6, 32'h0, 1'b0, 2, 1);
        run("st_h2",  0, 1'b1, 8'd2, 2'b01, 1'b0, 32'h0000_BBDD, 32'h0, 1'b0, 2, 1);
        run("ld_w0",  0, 1'b0, 8'd0, 2'b10, 1'b0, 32'h0, 32'hA600_BBDD, 1'b0, 2, 1);
        run("ld_bse", 0, 1'b0, 8'd0, 2'b00, 1'b1, 32'h0, 32'hFFFF_FFA6, 1'b0, 2, 1);
        run("ld_bze", 0, 1'b0, 8'd0, 2'b00, 1'b0, 32'h0, 32'h0000_00A6, 1'b0, 2, 1);
        run("st_w8",  0, 1'b1, 8'd8, 2'b10, 1'b0, 32'hABCD_EF01, 32'h0, 1'b0, 2, 1);
        run("ld_w8",  0, 1'b0, 8'd8, 2'b10, 1'b0, 32'h0, 32'hABCD_EF01, 1'b0, 2, 1);

        // Misaligned halfword and size 11
`ifdef DMAU_ALIGN_CHECK_EN
        run("ld_h3",  0, 1'b0, 8'd3, 2'b01, 1'b0, 32'h0, 32'h0, 1'b1, 1, 0);
        chk("hold_addr", {24'd0, mem_addr[0]}, 32'd3);
        run("ld_s11", 0, 1'b0, 8'd9, 2'b11, 1'b0, 32'h0, 32'h0, 1'b1, 1, 0);
`else
        run("ld_h3",  0, 1'b0, 8'd3, 2'b01, 1'b0, 32'h0, 32'h0000_BBDD, 1'b0, 2, 1);
        chk("hold_addr", {24'd0, mem_addr[0]}, 32'd2);
        run("ld_s11", 0, 1'b0, 8'd9, 2'b11, 1'b0, 32'h0, 32'hABCD_EF01, 1'b0, 2, 1);
`endif

        // Response back-pressure with a second request waiting
        @(negedge clk);
        req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[0] = 8'd0;
        req_size[0] = 2'b00; req_se[0] = 1'b0;
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        t = 0;
        while (!rsp_valid[0] && t < 20) begin @(negedge clk); t++; end
        chk("bp_valid", {31'd0, rsp_valid[0]}, 32'd1);
        req_valid[0] = 1'b1; req_addr[0] = 8'd8; req_size[0] = 2'b10;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_hold_v",  {31'd0, rsp_valid[0]}, 32'd1);
            chk("bp_hold_d",  rsp_data[0], 32'h0000_00A6);
            chk("bp_hold_rr", {31'd0, req_ready[0]}, 32'd0);
            chk("bp_hold_en", {31'd0, mem_en[0]}, 32'd0);
        end
        rsp_ready[0] = 1'b1;
        @(posedge clk);
        #1 rsp_ready[0] = 1'b0;
        @(negedge clk);
        chk("bp_idle_rr", {31'd0, req_ready[0]}, 32'd1);
        chk("bp_idle_v",  {31'd0, rsp_valid[0]}, 32'd0);
        chk("bp_not_taken", {31'd0, mem_en[0]}, 32'd0);
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        @(negedge clk);
        chk("bp_taken", {31'd0, mem_en[0]}, 32'd1);
        t = 0;
        while (!rsp_valid[0] && t < 20) begin @(negedge clk); t++; end
        chk("bp_second_d", rsp_data[0], 32'hABCD_EF01);
        rsp_ready[0] = 1'b1;
        @(posedge clk);
        #1 rsp_ready[0] = 1'b0;

        // MEM_LATENCY=3
        run("l3_st", 1, 1'b1, 8'h10, 2'b10, 1'b0, 32'h1234_5678, 32'h0, 1'b0, 4, 3);
        run("l3_ld", 1, 1'b0, 8'h10, 2'b10, 1'b0, 32'h0, 32'h1234_5678, 1'b0, 4, 3);

        // Reset in the middle of a store access
        @(negedge clk);
        req_valid[1] = 1'b1; req_write[1] = 1'b1; req_addr[1] = 8'h20;
        req_size[1] = 2'b10; req_data[1] = 32'h5566_7788;
        @(posedge clk);
        #1 req_valid[1] = 1'b0;
        @(negedge clk);
        chk("ar_pre_en", {31'd0, mem_en[1]}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("ar_en",   {31'd0, mem_en[1]}, 32'd0);
        chk("ar_rw",   {31'd0, mem_rw[1]}, 32'd0);
        chk("ar_rr",   {31'd0, req_ready[1]}, 32'd1);
        chk("ar_addr", {24'd0, mem_addr[1]}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (rsp_valid[1] || mem_en[1]) seen++;
        end
        chk("ar_no_rsp", seen, 32'd0);
        chk("ar_rr_after", {31'd0, req_ready[1]}, 32'd1);
        chk("ar_no_write", {24'd0, mem[1][8'h20]}, 32'd0);
        run("ar_resume", 1, 1'b0, 8'h10, 2'b10, 1'b0, 32'h0, 32'h1234_5678, 1'b0, 4, 3);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
